fp_divsqrt: RTL and testbench

Iterative IEEE-754 floating-point divide / square-root unit with a runtime mode select. Shares one radix-2 restoring datapath between both operations. Uses round-to-nearest-even on guard/round/sticky bits and reports IEEE exception flags. Sits beside the FP add/mul units behind the same start/done handshake and is the next-generation replacement for the single-mode divider.

---
 rtl/fp_divsqrt_pkg.sv | 32 +++
 rtl/fp_divsqrt_iter.sv | 71 +++++++
 rtl/fp_divsqrt.sv | 190 +++++++++++++++++++
 tb/tb_fp_divsqrt.sv | 110 +++++++++++
 4 files changed

// File: rtl/fp_divsqrt_pkg.sv
// Shared types for the iterative FP divide / square-root unit: FSM states,
// operand classification and the IEEE exception flag bundle.
package fp_divsqrt_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, OUT} state_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic div_zero;
  } fp_flags_t;

  // Subnormals have a zero exponent field and therefore classify as zero.
  function automatic fp_class_t classify(input logic sign, input logic exp_zero,
                                         input logic exp_ones, input logic frac_nz);
    fp_class_t c;
    c.sign = sign;
    c.zero = exp_zero;
    c.inf  = exp_ones & ~frac_nz;
    c.nan  = exp_ones & frac_nz;
    return c;
  endfunction

endpackage

// File: rtl/fp_divsqrt_iter.sv
// Radix-2 restoring iteration shared by divide and square root: one
// compare/subtract per cycle, one quotient/root bit per step.
module fp_divsqrt_iter #(
  parameter int MAN_W = 24,
  parameter int Q_W   = 27
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           sqrt,
  input  logic [MAN_W:0] num,
  input  logic [MAN_W-1:0] den,
  output logic [Q_W:0]   q,
  output logic           rem_nz,
  output logic           last
);
  localparam int N_IT = Q_W + 1;
  localparam int R_W  = Q_W + 5;
  localparam int C_W  = $clog2(N_IT);

  logic [R_W-1:0]    rem;
  logic [2*N_IT-1:0] rad;
  logic [N_IT-1:0]   q_r;
  logic [C_W-1:0]    cnt;
  logic [MAN_W-1:0]  den_r;
  logic              mode;

  logic [R_W-1:0] partial, lhs, rhs, kept, rem_next;
  logic [R_W:0]   diff;
  logic           ge;

  // Sqrt brings down two radicand bits per step and trials 4*root+1;
  // divide trials the divisor and shifts the partial remainder afterwards.
  assign partial  = {rem[R_W-3:0], rad[2*N_IT-1 -: 2]};
  assign lhs      = mode ? partial : rem;
  assign rhs      = mode ? R_W'({q_r, 2'b01}) : R_W'(den_r);
  assign diff     = {1'b0, lhs} - {1'b0, rhs};
  assign ge       = ~diff[R_W];
  assign kept     = ge ? diff[R_W-1:0] : lhs;
  assign rem_next = mode ? kept : kept << 1;

  assign q      = q_r;
  assign rem_nz = |rem;
  assign last   = (cnt == C_W'(N_IT - 1));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rem   <= '0;
      rad   <= '0;
      q_r   <= '0;
      cnt   <= '0;
      den_r <= '0;
      mode  <= 1'b0;
    end else if (load) begin
      rem   <= sqrt ? '0 : R_W'(num);
      rad   <= sqrt ? {num, {(2*N_IT-MAN_W-1){1'b0}}} : '0;
      q_r   <= '0;
      cnt   <= '0;
      den_r <= den;
      mode  <= sqrt;
    end else if (step) begin
      rem   <= rem_next;
      rad   <= rad << 2;
      q_r   <= {q_r[N_IT-2:0], ge};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fp_divsqrt.sv
// IEEE-754 divide / square root with runtime mode select, RNE rounding,
// flush-to-zero inputs and a start/done handshake.
module fp_divsqrt
  import fp_divsqrt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int EXTRA  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sqrt,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              invalid,
  output logic              div_zero
);
  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int MAN_W  = DATA_W - EXP_W;
  localparam int FRAC_W = MAN_W - 1;
  localparam int Q_W    = MAN_W + EXTRA;
  localparam int N_IT   = Q_W + 1;
  localparam int E_W    = EXP_W + 2;
  localparam logic signed [E_W-1:0] BIAS_E = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EMAX_E = E_W'(2**EXP_W - 1);
  localparam logic signed [E_W-1:0] ONE_E  = E_W'(1);
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  state_e                state;
  logic [DATA_W-1:0]     a_r, b_r, pend_res;
  logic                  mode_r, sign_r;
  logic signed [E_W-1:0] exp_r;
  fp_flags_t             pend_flags;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  fp_class_t        ca, cb;

  assign ea = a_r[DATA_W-2 -: EXP_W];
  assign eb = b_r[DATA_W-2 -: EXP_W];
  assign ma = {1'b1, a_r[FRAC_W-1:0]};
  assign mb = {1'b1, b_r[FRAC_W-1:0]};
  assign ca = classify(a_r[DATA_W-1], ea == '0, &ea, |a_r[FRAC_W-1:0]);
  assign cb = classify(b_r[DATA_W-1], eb == '0, &eb, |b_r[FRAC_W-1:0]);

  logic              sgn, special;
  logic [DATA_W-1:0] sp_res, inf_word, zero_word;
  fp_flags_t         sp_flags;

  assign sgn       = mode_r ? ca.sign : ca.sign ^ cb.sign;
  assign inf_word  = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign zero_word = {sgn, {(DATA_W-1){1'b0}}};

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    special  = 1'b1;
    sp_res   = zero_word;
    sp_flags = '0;
    if (mode_r) begin
      if (ca.nan || (ca.sign && !ca.zero)) begin
        sp_res           = QNAN;
        sp_flags.invalid = 1'b1;
      end else if (ca.inf)  sp_res  = inf_word;
      else if (!ca.zero)    special = 1'b0;
    end else begin
      if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
        sp_res           = QNAN;
        sp_flags.invalid = 1'b1;
      end else if (cb.zero && !ca.inf) begin
        sp_res            = inf_word;
        sp_flags.div_zero = 1'b1;
      end else if (ca.inf)            sp_res  = inf_word;
      else if (!(cb.inf || ca.zero))  special = 1'b0;
    end
  end

  // Sqrt: an odd unbiased exponent moves one factor of two into the radicand.
  logic signed [E_W-1:0] ea_s, eb_s, e_sq, exp_calc;
  logic [MAN_W:0]        num;

  assign ea_s     = $signed({2'b00, ea});
  assign eb_s     = $signed({2'b00, eb});
  assign e_sq     = ea_s - BIAS_E;
  assign exp_calc = mode_r ? $signed({e_sq[E_W-1], e_sq[E_W-1:1]}) + BIAS_E
                           : ea_s - eb_s + BIAS_E;
  assign num      = (mode_r && e_sq[0]) ? {ma, 1'b0} : {1'b0, ma};

  logic [N_IT-1:0]       q;
  logic                  rem_nz, last, load, step;
  logic [Q_W-1:0]        field;
  logic                  sticky, rnd_up;
  logic signed [E_W-1:0] exp_n, exp_f;
  logic [MAN_W:0]        man_r;
  logic [DATA_W-1:0]     rnd_res;
  fp_flags_t             rnd_flags;

  assign load = (state == UNPACK) && !special;
  assign step = (state == ITER);

  fp_divsqrt_iter #(.MAN_W(MAN_W), .Q_W(Q_W)) u_iter (
    .clk(clk), .rst(rst), .load(load), .step(step), .sqrt(mode_r),
    .num(num), .den(mb), .q(q), .rem_nz(rem_nz), .last(last)
  );

  always_comb begin
    if (q[N_IT-1]) begin
      field  = q[N_IT-1:1];
      sticky = q[0] | rem_nz;
      exp_n  = exp_r;
    end else begin
      field  = q[Q_W-1:0];
      sticky = rem_nz;
      exp_n  = exp_r - ONE_E;
    end
    rnd_up    = field[EXTRA-1] & (field[EXTRA] | (|field[EXTRA-2:0]) | sticky);
    man_r     = {1'b0, field[Q_W-1:EXTRA]} + {{MAN_W{1'b0}}, rnd_up};
    exp_f     = man_r[MAN_W] ? exp_n + ONE_E : exp_n;
    rnd_flags = '0;
    if (exp_f >= EMAX_E) begin
      rnd_res            = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rnd_flags.overflow = 1'b1;
    end else if (exp_f < ONE_E) begin
      rnd_res             = {sign_r, {(DATA_W-1){1'b0}}};
      rnd_flags.underflow = 1'b1;
    end else begin
      rnd_res = {sign_r, exp_f[EXP_W-1:0],
                 man_r[MAN_W] ? man_r[MAN_W-1:1] : man_r[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      mode_r     <= 1'b0;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      pend_res   <= '0;
      pend_flags <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res        <= '0;
      {overflow, underflow, invalid, div_zero} <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          a_r    <= op_a;
          b_r    <= op_b;
          mode_r <= sqrt;
          busy   <= 1'b1;
          state  <= UNPACK;
        end
        UNPACK: begin
          sign_r <= sgn;
          exp_r  <= exp_calc;
          if (special) begin
            pend_res   <= sp_res;
            pend_flags <= sp_flags;
            state      <= OUT;
          end else begin
            state <= ITER;
          end
        end
        ITER: if (last) state <= ROUND;
        ROUND: begin
          pend_res   <= rnd_res;
          pend_flags <= rnd_flags;
          state      <= OUT;
        end
        OUT: begin
          res   <= pend_res;
          {overflow, underflow, invalid, div_zero} <= pend_flags;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divsqrt.sv
// Directed bench for fp_divsqrt: hand-computed results, flags and latencies,
// back-to-back launch, dropped start while busy and mid-operation reset.
module tb_fp_divsqrt;
  logic        clk = 1'b0;
  logic        rst, start, sqrt;
  logic [31:0] op_a, op_b, res;
  logic        busy, done, overflow, underflow, invalid, div_zero;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [3:0] F_OVF = 4'b1000, F_UNF = 4'b0100, F_INV = 4'b0010, F_DZ = 4'b0001;

  always #5 clk = ~clk;

  fp_divsqrt dut (
    .clk(clk), .rst(rst), .start(start), .sqrt(sqrt), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .res(res), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_flags();
    return {28'd0, overflow, underflow, invalid, div_zero};
  endfunction

  // Launches one operation; glitch_at >= 0 pulses a conflicting start that
  // many cycles later, which must be ignored.
  task automatic run_op(input string tag, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [3:0] exp_fl, input int exp_lat, input int glitch_at);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; sqrt = m; op_a = a; op_b = b;
    @(posedge clk); #1;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == glitch_at) begin
        start = 1'b1; sqrt = ~m; op_a = 32'h40800000; op_b = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " res"}, res, exp_res);
    check({tag, " flags"}, get_flags(), {28'd0, exp_fl});
    check({tag, " busy"}, {busy_ok, busy}, 2'b10);
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1; start = 1'b0; sqrt = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset res", res, 32'h0);
    check("reset ctl", {busy, done, get_flags()}, 34'h0);

    run_op("div 6/2",    1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0, 31, -1);
    run_op("div 1/3",    1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0, 31, -1);
    run_op("div 1/3 b2b", 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0, 31, -1);
    run_op("sqrt 2",     1'b1, 32'h40000000, 32'hDEADBEEF, 32'h3FB504F3, 4'b0, 31, -1);
    run_op("sqrt 4",     1'b1, 32'h40800000, 32'h00000000, 32'h40000000, 4'b0, 31, -1);
    run_op("sqrt -0",    1'b1, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0, 2, -1);
    run_op("div 1/0",    1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, F_DZ, 2, -1);
    run_op("sqrt -1",    1'b1, 32'hBF800000, 32'h00000000, 32'h7FC00000, F_INV, 2, -1);
    run_op("div 0/0",    1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, F_INV, 2, -1);
    run_op("div ovf",    1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, F_OVF, 31, -1);
    run_op("div unf",    1'b0, 32'h00800000, 32'h40800000, 32'h00000000, F_UNF, 31, -1);
    run_op("div busy start", 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0, 31, 5);

    // Abort in the middle of the iteration phase.
    @(negedge clk);
    start = 1'b1; sqrt = 1'b0; op_a = 32'h40C00000; op_b = 32'h40000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre-abort busy", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort res", res, 32'h0);
    check("abort ctl", {busy, done, get_flags()}, 34'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort quiet", {31'd0, saw_done}, 32'h0);

    run_op("sqrt 4 after abort", 1'b1, 32'h40800000, 32'h0, 32'h40000000, 4'b0, 31, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
